// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order imem reads, buffers PC-tagged words in a
// prefetch FIFO, and flushes/drains on a PCSrc redirect.
module fetch_unit #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] Instr,
   output logic [31:0] PCPlus8,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        PCSrc,
   input  logic [31:0] PCTarget
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   typedef enum logic [0:0] {StRun, StDrain} state_e;

   state_e          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   occ_q, occ_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [31:0]     fifo_instr_q [DEPTH];
   logic [31:0]     fifo_pc8_q [DEPTH];

   logic [CW:0]     inflight;
   logic            accept;
   logic            out_dec;
   logic            drop_dec;
   logic            push;
   logic            pop;
   logic            unused_target_lsbs;

   assign unused_target_lsbs = ^PCTarget[1:0];

   // Outstanding requests plus buffered words bounds FIFO occupancy, so a push never overflows.
   assign inflight       = {1'b0, outstanding_q} + {1'b0, occ_q};
   assign imem_req_valid = !reset && (state_q == StRun) && !PCSrc && (inflight < DEPTH_W);
   assign imem_req_addr  = fetch_pc_q;
   assign accept         = imem_req_valid && imem_req_ready;

   assign out_dec  = imem_rsp_valid && (state_q == StRun) && (outstanding_q != '0);
   assign drop_dec = imem_rsp_valid && (state_q == StDrain) && (drop_cnt_q != '0);
   assign push     = out_dec && !PCSrc;
   assign pop      = instr_valid && instr_ready && !PCSrc;

   assign instr_valid = (occ_q != '0);
   assign Instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
   assign PCPlus8     = instr_valid ? fifo_pc8_q[rd_ptr_q] : 32'h0;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      occ_d         = occ_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;

      if (PCSrc) begin
         fetch_pc_d    = {PCTarget[31:2], 2'b00};
         rsp_pc_d      = {PCTarget[31:2], 2'b00};
         outstanding_d = '0;
         // Everything still in flight at the redirect must be thrown away when it returns.
         drop_cnt_d    = (drop_cnt_q - CW'(drop_dec)) + (outstanding_q - CW'(out_dec));
         occ_d         = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         state_d       = (drop_cnt_d != '0) ? StDrain : StRun;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         outstanding_d = outstanding_q + CW'(accept) - CW'(out_dec);
         drop_cnt_d    = drop_cnt_q - CW'(drop_dec);
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         occ_d = occ_q + CW'(push) - CW'(pop);
         if ((state_q == StDrain) && (drop_cnt_d == '0)) begin
            state_d = StRun;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StRun;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         occ_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         occ_q         <= occ_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head is masked by occ_q.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
         fifo_pc8_q[wr_ptr_q]   <= rsp_pc_q + 32'd8;
      end
   end

endmodule
